// File: rtl/stage_fetch.sv
// RV32I fetch stage: credit-limited imem requests, epoch-tagged responses,
// response FIFO and IF-ID register. Optional trap: `define MISALIGN_TRAP_EN.

package stage_fetch_pkg;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus_four;
      logic        instr_valid;
   } if_id_reg_t;
endpackage

module stage_fetch
   import stage_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        instr_jal_i,
   input  logic        instr_jalr_i,
   input  logic        branch_taken_i,
   input  logic [31:0] jal_addr_i,
   input  logic [31:0] jalr_addr_i,
   input  logic [31:0] branch_addr_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_o,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign_o,
`endif
   output if_id_reg_t  if_id_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [31:0]   r_fetch_pc;
   logic          r_epoch;
   logic [CW-1:0] r_outst;
   logic          r_tag_q [FIFO_DEPTH];
   logic [31:0]   r_tpc_q [FIFO_DEPTH];
   logic [AW-1:0] r_t_wp;
   logic [AW-1:0] r_t_rp;
   logic [31:0]   r_f_pc  [FIFO_DEPTH];
   logic [31:0]   r_f_ins [FIFO_DEPTH];
   logic [AW-1:0] r_f_wp;
   logic [AW-1:0] r_f_rp;
   logic [CW-1:0] r_f_cnt;
   logic [31:0]   r_instr;
   if_id_reg_t    r_if_id;

   logic          w_redirect;
   logic [31:0]   w_target;
   logic          w_halt;
   logic [CW:0]   w_used;
   logic          w_issue;
   logic          w_rsp;
   logic          w_rsp_ok;
   logic          w_deq;
   logic          w_pop;
   logic          w_byp;
   logic          w_push;

   always_comb begin
      w_target = branch_addr_i;
      if (instr_jalr_i)
         w_target = jalr_addr_i;
      else if (instr_jal_i)
         w_target = jal_addr_i;
   end

   assign w_redirect  = (instr_jalr_i | instr_jal_i | branch_taken_i)
                      & ~stall_i;
   assign w_used      = {1'b0, r_outst} + {1'b0, r_f_cnt};
   assign imem_req_o  = ~rst_i & ~w_halt & (w_used < {1'b0, FULL});
   assign imem_addr_o = r_fetch_pc;
   assign w_issue     = imem_req_o & imem_gnt_i;

   // Responses with nothing outstanding are stale (pre-reset) and ignored
   assign w_rsp    = imem_rvalid_i & (r_outst != '0);
   assign w_rsp_ok = w_rsp & (r_tag_q[r_t_rp] == r_epoch)
                   & ~w_redirect & ~w_halt;
   assign w_deq    = ~stall_i & ~w_redirect & ~w_halt;
   assign w_pop    = w_deq & (r_f_cnt != '0);
   assign w_byp    = w_deq & (r_f_cnt == '0) & w_rsp_ok;
   assign w_push   = w_rsp_ok & ~w_byp;

`ifdef MISALIGN_TRAP_EN
   logic r_mis;
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i)
         r_mis <= 1'b0;
      else if (w_redirect && (w_target[1:0] != 2'b00))
         r_mis <= 1'b1;
   end
   assign w_halt     = r_mis;
   assign misalign_o = r_mis;
`else
   assign w_halt = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_tag_q[r_t_wp] <= r_epoch;
         r_tpc_q[r_t_wp] <= r_fetch_pc;
      end
      if (w_push) begin
         r_f_pc[r_f_wp]  <= r_tpc_q[r_t_rp];
         r_f_ins[r_f_wp] <= imem_rdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_fetch_pc <= RESET_PC;
         r_epoch    <= 1'b0;
         r_outst    <= '0;
         r_t_wp     <= '0;
         r_t_rp     <= '0;
         r_f_wp     <= '0;
         r_f_rp     <= '0;
         r_f_cnt    <= '0;
         r_instr    <= NOP_INSTR;
         r_if_id    <= '0;
      end else begin
         // A grant on the redirect cycle keeps the old tag and is dropped later
         if (w_redirect) begin
            r_fetch_pc <= w_target & 32'hFFFF_FFFC;
            r_epoch    <= ~r_epoch;
         end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_issue)
            r_t_wp <= r_t_wp + AW'(1);
         if (w_rsp)
            r_t_rp <= r_t_rp + AW'(1);
         unique case ({w_issue, w_rsp})
            2'b10:   r_outst <= r_outst + CW'(1);
            2'b01:   r_outst <= r_outst - CW'(1);
            default: ;
         endcase
         if (w_redirect) begin
            r_f_wp  <= '0;
            r_f_rp  <= '0;
            r_f_cnt <= '0;
         end else begin
            if (w_push)
               r_f_wp <= r_f_wp + AW'(1);
            if (w_pop)
               r_f_rp <= r_f_rp + AW'(1);
            unique case ({w_push, w_pop})
               2'b10:   r_f_cnt <= r_f_cnt + CW'(1);
               2'b01:   r_f_cnt <= r_f_cnt - CW'(1);
               default: ;
            endcase
         end
         if (!stall_i) begin
            if (w_pop) begin
               r_instr              <= r_f_ins[r_f_rp];
               r_if_id.pc           <= r_f_pc[r_f_rp];
               r_if_id.pc_plus_four <= r_f_pc[r_f_rp] + 32'd4;
               r_if_id.instr_valid  <= 1'b1;
            end else if (w_byp) begin
               r_instr              <= imem_rdata_i;
               r_if_id.pc           <= r_tpc_q[r_t_rp];
               r_if_id.pc_plus_four <= r_tpc_q[r_t_rp] + 32'd4;
               r_if_id.instr_valid  <= 1'b1;
            end else begin
               r_instr             <= NOP_INSTR;
               r_if_id.instr_valid <= 1'b0;
            end
         end
      end
   end

   assign instr_o = r_instr;
   assign if_id_o = r_if_id;

   a_fifo_no_ovf: assert property (@(posedge clk) disable iff (rst_i)
      !(w_push && !w_pop && (r_f_cnt == FULL)));

endmodule
